// File: rtl/pht_update_scheduler_pkg.sv
// Shared fetch-unit types for the PHT update path: index/counter widths,
// the queued update entry and the scheduler state encoding.
package pht_update_scheduler_pkg;

    localparam int PHT_INDEX_WIDTH       = 8;
    localparam int PHT_ENTRY_WIDTH       = 2;
    localparam int PHT_UPDATE_QUEUE_SIZE = 32;
    localparam int PHT_UPDATE_WIDTH      = 2;
    localparam int PHT_STARVE_LIMIT      = 16;

    typedef logic [PHT_INDEX_WIDTH-1:0] PHT_IndexPath;
    typedef logic [PHT_ENTRY_WIDTH-1:0] PHT_EntryPath;

    typedef struct packed {
        PHT_IndexPath idx;
        PHT_EntryPath val;
    } PhtUpdateEntry;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FORCE = 2'd2
    } PhtUpdSchedState;

endpackage

// File: rtl/pht_update_fifo.sv
// Multi-push / single-pop circular buffer of PHT updates. Valid push lanes are
// compacted in lane order onto the tail; the count tells full apart from empty.
module pht_update_fifo
    import pht_update_scheduler_pkg::*;
#(
    parameter int UPD_WIDTH  = PHT_UPDATE_WIDTH,
    parameter int QUEUE_SIZE = PHT_UPDATE_QUEUE_SIZE,
    localparam int AW = $clog2(QUEUE_SIZE),
    localparam int CW = $clog2(QUEUE_SIZE) + 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic          [UPD_WIDTH-1:0]   pushValid,
    input  PhtUpdateEntry [UPD_WIDTH-1:0]   pushData,
    input  logic                            popEn,
    output PhtUpdateEntry                   headData,
    output logic          [CW-1:0]          count,
    output logic                            empty
);

    PhtUpdateEntry     mem_q [QUEUE_SIZE];
    logic [AW-1:0]     head_q;
    logic [AW-1:0]     tail_q;
    logic [CW-1:0]     count_q;
    logic [AW-1:0]     laneSlot [UPD_WIDTH];
    logic [CW-1:0]     pushCnt;

    // Each valid lane lands after the valid lanes below it, skipping gaps.
    always_comb begin
        pushCnt = '0;
        for (int i = 0; i < UPD_WIDTH; i++) begin
            laneSlot[i] = tail_q + pushCnt[AW-1:0];
            if (pushValid[i]) begin
                pushCnt = pushCnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < UPD_WIDTH; i++) begin
            if (pushValid[i]) begin
                mem_q[laneSlot[i]] <= pushData[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_q + AW'(popEn);
            tail_q  <= tail_q + pushCnt[AW-1:0];
            count_q <= count_q + pushCnt - CW'(popEn);
        end
    end

    assign headData = mem_q[head_q];
    assign count    = count_q;
    assign empty    = (count_q == '0);

endmodule

// File: rtl/pht_update_scheduler.sv
// Shares the single-ported PHT between fetch reads and queued commit updates,
// forcing a drain when fetch starves the queue. Optional PHT_UPDATE_BYPASS_EN
// sends lane 0 straight to the write port when the queue is empty and idle.
module pht_update_scheduler
    import pht_update_scheduler_pkg::*;
#(
    parameter int UPD_WIDTH    = PHT_UPDATE_WIDTH,
    parameter int QUEUE_SIZE   = PHT_UPDATE_QUEUE_SIZE,
    parameter int STARVE_LIMIT = PHT_STARVE_LIMIT,
    localparam int CW = $clog2(QUEUE_SIZE) + 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [UPD_WIDTH-1:0]                  updValid,
    input  logic [UPD_WIDTH*PHT_INDEX_WIDTH-1:0]  updIndex,
    input  logic [UPD_WIDTH*PHT_ENTRY_WIDTH-1:0]  updValue,
    output logic                                  updReady,
    input  logic                                  fetchRead,
    output logic                                  fetchStall,
    output logic                                  phtWE,
    output logic [PHT_INDEX_WIDTH-1:0]            phtWA,
    output logic [PHT_ENTRY_WIDTH-1:0]            phtWV,
    output logic [CW-1:0]                         queueCount,
    output logic                                  overflow
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    PhtUpdSchedState               state_q, state_d;
    logic [SW-1:0]                 starve_q, starve_d;
    logic                          phtWE_q;
    PHT_IndexPath                  phtWA_q;
    PHT_EntryPath                  phtWV_q;
    logic                          overflow_q;

    PhtUpdateEntry [UPD_WIDTH-1:0] laneEntry;
    logic [UPD_WIDTH-1:0]          pushValid;
    logic                          pushAny;
    logic                          popEn;
    logic                          bypassTake;
    logic                          fifoEmpty;
    PhtUpdateEntry                 headEntry;
    logic [CW-1:0]                 fifoCount;
    logic [CW-1:0]                 freeSlots;

    // Readiness is judged on the pre-pop count, so a same-cycle pop earns no credit.
    assign freeSlots = CW'(QUEUE_SIZE) - fifoCount;
    assign updReady  = (freeSlots >= CW'(UPD_WIDTH));

    always_comb begin
        for (int i = 0; i < UPD_WIDTH; i++) begin
            laneEntry[i].idx = updIndex[i*PHT_INDEX_WIDTH +: PHT_INDEX_WIDTH];
            laneEntry[i].val = updValue[i*PHT_ENTRY_WIDTH +: PHT_ENTRY_WIDTH];
        end
    end

`ifdef PHT_UPDATE_BYPASS_EN
    assign bypassTake = fifoEmpty && !fetchRead && updValid[0] && updReady;
`else
    assign bypassTake = 1'b0;
`endif

    always_comb begin
        pushValid = updReady ? updValid : '0;
        pushValid[0] = pushValid[0] & ~bypassTake;
    end

    assign pushAny = |pushValid;

    pht_update_fifo #(
        .UPD_WIDTH  (UPD_WIDTH),
        .QUEUE_SIZE (QUEUE_SIZE)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .pushValid (pushValid),
        .pushData  (laneEntry),
        .popEn     (popEn),
        .headData  (headEntry),
        .count     (fifoCount),
        .empty     (fifoEmpty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    // Fetch owns the port except in FORCE; the last pop with no refill returns to IDLE.
    always_comb begin
        state_d    = state_q;
        starve_d   = starve_q;
        popEn      = 1'b0;
        fetchStall = 1'b0;
        case (state_q)
            IDLE: begin
                if (pushAny) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (fifoEmpty) begin
                    state_d  = IDLE;
                    starve_d = '0;
                end else if (!fetchRead) begin
                    popEn    = 1'b1;
                    starve_d = '0;
                    if ((fifoCount == CW'(1)) && !pushAny) begin
                        state_d = IDLE;
                    end
                end else begin
                    starve_d = starve_q + SW'(1);
                    if (starve_q == SW'(STARVE_LIMIT - 1)) begin
                        state_d = FORCE;
                    end
                end
            end
            FORCE: begin
                fetchStall = 1'b1;
                popEn      = !fifoEmpty;
                starve_d   = '0;
                if ((fifoCount <= CW'(1)) && !pushAny) begin
                    state_d = IDLE;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d  = IDLE;
                starve_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phtWE_q    <= 1'b0;
            phtWA_q    <= '0;
            phtWV_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            phtWE_q <= popEn | bypassTake;
            if (popEn) begin
                phtWA_q <= headEntry.idx;
                phtWV_q <= headEntry.val;
            end else if (bypassTake) begin
                phtWA_q <= laneEntry[0].idx;
                phtWV_q <= laneEntry[0].val;
            end
            if ((|updValid) && !updReady) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign phtWE      = phtWE_q;
    assign phtWA      = phtWA_q;
    assign phtWV      = phtWV_q;
    assign queueCount = fifoCount;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_pht_update_scheduler.sv
// Directed self-checking bench for pht_update_scheduler (UPD_WIDTH=2,
// QUEUE_SIZE=32, STARVE_LIMIT=16); honours PHT_UPDATE_BYPASS_EN for latency.
module tb_pht_update_scheduler;
    import pht_update_scheduler_pkg::*;

    logic        clk;
    logic        rst;
    logic [1:0]  updValid;
    logic [15:0] updIndex;
    logic [3:0]  updValue;
    logic        updReady;
    logic        fetchRead;
    logic        fetchStall;
    logic        phtWE;
    logic [7:0]  phtWA;
    logic [1:0]  phtWV;
    logic [5:0]  queueCount;
    logic        overflow;

    int testsRun    = 0;
    int testsFailed = 0;

    logic [7:0] expIdx [40];
    logic [1:0] expVal [40];
    int         wrPtr     = 0;
    bit         monitorOn = 1'b0;

    pht_update_scheduler #(
        .UPD_WIDTH    (2),
        .QUEUE_SIZE   (32),
        .STARVE_LIMIT (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .updValid   (updValid),
        .updIndex   (updIndex),
        .updValue   (updValue),
        .updReady   (updReady),
        .fetchRead  (fetchRead),
        .fetchStall (fetchStall),
        .phtWE      (phtWE),
        .phtWA      (phtWA),
        .phtWV      (phtWV),
        .queueCount (queueCount),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] valid, input logic [7:0] idx0,
                                 input logic [1:0] val0, input logic [7:0] idx1,
                                 input logic [1:0] val1, input logic fetch);
        updValid  = valid;
        updIndex  = {idx1, idx0};
        updValue  = {val1, val0};
        fetchRead = fetch;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        applyStimulus(2'b00, 8'h00, 2'd0, 8'h00, 2'd0, 1'b0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Write-order scoreboard used while the long wrap-around sequence runs.
    always @(posedge clk) begin
        #1;
        if (monitorOn && phtWE) begin
            if (wrPtr < 40) begin
                checkOutput($sformatf("t4_wa_%0d", wrPtr), 32'(phtWA), 32'(expIdx[wrPtr]));
                checkOutput($sformatf("t4_wv_%0d", wrPtr), 32'(phtWV), 32'(expVal[wrPtr]));
            end else begin
                checkOutput("t4_extra_write", 32'(phtWE), 32'(0));
            end
            wrPtr++;
        end
    end

    initial begin
        int early;
        int pushed;
        int budget;
        int weSeen;
        rst = 1'b1;
        applyStimulus(2'b00, 8'h00, 2'd0, 8'h00, 2'd0, 1'b0);

        // Reset values
        doReset();
        checkOutput("rst_count",    32'(queueCount), 32'(0));
        checkOutput("rst_ready",    32'(updReady),   32'(1));
        checkOutput("rst_we",       32'(phtWE),      32'(0));
        checkOutput("rst_wa",       32'(phtWA),      32'(0));
        checkOutput("rst_wv",       32'(phtWV),      32'(0));
        checkOutput("rst_stall",    32'(fetchStall), 32'(0));
        checkOutput("rst_overflow", 32'(overflow),   32'(0));

        // Test 1: single update latency
        applyStimulus(2'b01, 8'h12, 2'd3, 8'h00, 2'd0, 1'b0);
        stepCycle();
        applyStimulus(2'b00, 8'h00, 2'd0, 8'h00, 2'd0, 1'b0);
`ifdef PHT_UPDATE_BYPASS_EN
        checkOutput("t1_we", 32'(phtWE), 32'(1));
        checkOutput("t1_wa", 32'(phtWA), 32'(8'h12));
        checkOutput("t1_wv", 32'(phtWV), 32'(3));
`else
        checkOutput("t1_we_early", 32'(phtWE), 32'(0));
        stepCycle();
        checkOutput("t1_we", 32'(phtWE), 32'(1));
        checkOutput("t1_wa", 32'(phtWA), 32'(8'h12));
        checkOutput("t1_wv", 32'(phtWV), 32'(3));
`endif
        stepCycle();
        checkOutput("t1_we_once", 32'(phtWE), 32'(0));

        // Test 2: starvation forces a drain
        doReset();
        applyStimulus(2'b11, 8'h01, 2'd1, 8'h02, 2'd2, 1'b1);
        stepCycle();
        applyStimulus(2'b00, 8'h00, 2'd0, 8'h00, 2'd0, 1'b1);
        for (int e = 0; e < 2; e++) begin
            early = 0;
            for (int k = 0; k < 16; k++) begin
                if (k > 0) stepCycle();
                if (fetchStall) early++;
                if (k > 0 && phtWE) early++;
            end
            checkOutput($sformatf("t2_quiet_%0d", e), 32'(early), 32'(0));
            stepCycle();
            checkOutput($sformatf("t2_stall_%0d", e), 32'(fetchStall), 32'(1));
            checkOutput($sformatf("t2_nowe_%0d", e),  32'(phtWE),      32'(0));
            stepCycle();
            checkOutput($sformatf("t2_we_%0d", e),    32'(phtWE),      32'(1));
            checkOutput($sformatf("t2_wa_%0d", e),    32'(phtWA),      32'(e + 1));
            checkOutput($sformatf("t2_unstall_%0d", e), 32'(fetchStall), 32'(0));
        end
        checkOutput("t2_count", 32'(queueCount), 32'(0));
        stepCycle();
        checkOutput("t2_idle_we", 32'(phtWE), 32'(0));

        // Test 3: fill to 31, then overflow
        doReset();
        for (int c = 0; c < 15; c++) begin
            applyStimulus(2'b11, 8'(2*c), 2'd1, 8'(2*c+1), 2'd2, 1'b1);
            stepCycle();
        end
        applyStimulus(2'b01, 8'h3E, 2'd3, 8'h00, 2'd0, 1'b1);
        stepCycle();
        checkOutput("t3_count31", 32'(queueCount), 32'(31));
        checkOutput("t3_notready", 32'(updReady),  32'(0));
        checkOutput("t3_noovf",   32'(overflow),   32'(0));
        applyStimulus(2'b01, 8'h55, 2'd1, 8'h00, 2'd0, 1'b1);
        stepCycle();
        checkOutput("t3_ovf",      32'(overflow),   32'(1));
        checkOutput("t3_count_kept", 32'(queueCount), 32'(31));
        applyStimulus(2'b00, 8'h00, 2'd0, 8'h00, 2'd0, 1'b1);
        stepCycle();
        checkOutput("t3_ovf_sticky", 32'(overflow), 32'(1));

        // Test 4: 40 updates in order across the pointer wrap
        doReset();
        for (int n = 0; n < 40; n++) begin
            expIdx[n] = 8'(8'h40 + n);
            expVal[n] = 2'(n % 4);
        end
        wrPtr     = 0;
        monitorOn = 1'b1;
        pushed    = 0;
        for (int c = 0; pushed < 40; c++) begin
            if ((c % 4 == 0) && (pushed < 39)) begin
                applyStimulus(2'b11, expIdx[pushed], expVal[pushed],
                              expIdx[pushed+1], expVal[pushed+1], (c % 5 == 0));
                pushed += 2;
            end else begin
                applyStimulus(2'b01, expIdx[pushed], expVal[pushed],
                              8'h00, 2'd0, (c % 5 == 0));
                pushed += 1;
            end
            stepCycle();
        end
        applyStimulus(2'b00, 8'h00, 2'd0, 8'h00, 2'd0, 1'b0);
        budget = 0;
        while (queueCount != 0 && budget < 100) begin
            stepCycle();
            budget++;
        end
        checkOutput("t4_drain_bound", 32'(budget < 100), 32'(1));
        stepCycle();
        stepCycle();
        monitorOn = 1'b0;
        checkOutput("t4_writes", 32'(wrPtr),       32'(40));
        checkOutput("t4_count",  32'(queueCount),  32'(0));
        checkOutput("t4_idle",   32'(dut.state_q), 32'(IDLE));
        checkOutput("t4_ovf",    32'(overflow),    32'(0));

        // Test 5: lane gaps and duplicate indices
        doReset();
        applyStimulus(2'b10, 8'h00, 2'd0, 8'h07, 2'd1, 1'b0);
        stepCycle();
        applyStimulus(2'b00, 8'h00, 2'd0, 8'h00, 2'd0, 1'b0);
        checkOutput("t5_one_queued", 32'(queueCount), 32'(1));
        stepCycle();
        checkOutput("t5_we", 32'(phtWE), 32'(1));
        checkOutput("t5_wa", 32'(phtWA), 32'(8'h07));
        checkOutput("t5_wv", 32'(phtWV), 32'(1));
        doReset();
        applyStimulus(2'b11, 8'h07, 2'd2, 8'h07, 2'd3, 1'b0);
        stepCycle();
        applyStimulus(2'b00, 8'h00, 2'd0, 8'h00, 2'd0, 1'b0);
`ifdef PHT_UPDATE_BYPASS_EN
        checkOutput("t5_dup_count", 32'(queueCount), 32'(1));
`else
        checkOutput("t5_dup_count", 32'(queueCount), 32'(2));
        stepCycle();
`endif
        checkOutput("t5_dup0_we", 32'(phtWE), 32'(1));
        checkOutput("t5_dup0_wa", 32'(phtWA), 32'(8'h07));
        checkOutput("t5_dup0_wv", 32'(phtWV), 32'(2));
        stepCycle();
        checkOutput("t5_dup1_we", 32'(phtWE), 32'(1));
        checkOutput("t5_dup1_wv", 32'(phtWV), 32'(3));

        // Test 6: asynchronous reset in the middle of a drain
        doReset();
        for (int c = 0; c < 5; c++) begin
            applyStimulus(2'b11, 8'(8'h60 + 2*c), 2'd1, 8'(8'h61 + 2*c), 2'd2, 1'b1);
            stepCycle();
        end
        applyStimulus(2'b00, 8'h00, 2'd0, 8'h00, 2'd0, 1'b0);
        checkOutput("t6_count10", 32'(queueCount), 32'(10));
        stepCycle();
        stepCycle();
        checkOutput("t6_draining", 32'(phtWE), 32'(1));
        #2;
        rst = 1'b1;
        #1;
        checkOutput("t6_we_cleared",    32'(phtWE),      32'(0));
        checkOutput("t6_count_cleared", 32'(queueCount), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        weSeen = 0;
        for (int k = 0; k < 6; k++) begin
            stepCycle();
            if (phtWE) weSeen++;
        end
        checkOutput("t6_no_writes", 32'(weSeen), 32'(0));

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
